// File: rtl/banner_pkg.sv
// banner_pkg: shared message/mode encodings and default bitmap geometry for the banner renderer
package banner_pkg;
    localparam int MSG_W_DEF = 72;
    localparam int MSG_H_DEF = 16;
    typedef enum logic [1:0] {
        MSG_GAME_OVER = 2'd0,
        MSG_READY     = 2'd1,
        MSG_YOU_WIN   = 2'd2,
        MSG_PAUSED    = 2'd3
    } msg_e;
    typedef enum logic [1:0] {
        STATIC = 2'd0,
        BLINK  = 2'd1,
        REVEAL = 2'd2
    } mode_e;
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'd1) ? BLINK : (m == 2'd2) ? REVEAL : STATIC;
    endfunction
endpackage

// File: rtl/banner_rom.sv
// banner_rom: constant glyph table of all messages, one registered row word per lookup
module banner_rom
    import banner_pkg::*;
#(
    parameter int MSG_W   = MSG_W_DEF,
    parameter int MSG_H   = MSG_H_DEF,
    parameter int NUM_MSG = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [$clog2(NUM_MSG)-1:0] msg,
    input  logic [$clog2(MSG_H)-1:0]   row,
    output logic [MSG_W-1:0]           word
);
    localparam int TOP = 3;
    localparam logic [71:0] TEXT [4] = '{"GAME OVER", "  READY  ", " YOU WIN ", " PAUSED  "};

    function automatic logic [34:0] glyph(input logic [7:0] ch);
        case (ch)
            "A": glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
            "D": glyph = 35'b11110_10001_10001_10001_10001_10001_11110;
            "E": glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
            "G": glyph = 35'b01110_10001_10000_10111_10001_10001_01110;
            "I": glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
            "M": glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
            "N": glyph = 35'b10001_11001_10101_10011_10001_10001_10001;
            "O": glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
            "P": glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
            "R": glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
            "S": glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
            "U": glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
            "V": glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
            "W": glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
            "Y": glyph = 35'b10001_10001_01010_00100_00100_00100_00100;
            default: glyph = '0;
        endcase
    endfunction

    // Each character occupies an 8-column cell with its 5x7 glyph at cell columns 1..5, rows TOP..TOP+6
    function automatic logic [MSG_W-1:0] row_word(input int m, input int r);
        logic [MSG_W-1:0] w;
        logic [34:0] g;
        int fr;
        int j;
        w = '0;
        fr = r - TOP;
        for (int c = 0; c < MSG_W; c++) begin
            j = c % 8;
            if (fr >= 0 && fr < 7 && c / 8 < 9 && j >= 1 && j <= 5 && m < 4) begin
                g = glyph(TEXT[m][71 - 8 * (c / 8) -: 8]);
                w[MSG_W-1-c] = g[34 - 5 * fr - (j - 1)];
            end
        end
        return w;
    endfunction

    // Registered row lookup; column 0 lands in the MSB
    always_ff @(posedge Clk) begin
        if (Reset) word <= '0;
        else word <= row_word(int'(msg), int'(row));
    end
endmodule

// File: rtl/banner_renderer.sv
// banner_renderer: scaled multi-message text banner overlay with blink and reveal modes
module banner_renderer
    import banner_pkg::*;
#(
    parameter int MSG_W        = MSG_W_DEF,
    parameter int MSG_H        = MSG_H_DEF,
    parameter int NUM_MSG      = 4,
    parameter int SCALE_LOG2   = 1,
    parameter int X0           = 248,
    parameter int Y0           = 224,
    parameter int BLINK_FRAMES = 30,
    parameter int COORD_W      = 10
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic                       frame_start,
    input  logic                       show,
    input  logic [$clog2(NUM_MSG)-1:0] msg_sel,
    input  logic [1:0]                 mode,
    output logic                       pixel_on,
    output logic                       reveal_done,
    output logic [$clog2(NUM_MSG)-1:0] active_msg
);
    localparam int CW  = $clog2(MSG_W);
    localparam int RW  = $clog2(MSG_H);
    localparam int RCW = $clog2(MSG_W + 1);
    localparam int BW  = $clog2(BLINK_FRAMES + 1);

    logic              show_q, blink_phase, restart;
    mode_e             active_mode, new_mode;
    logic [BW-1:0]     blink_cnt;
    logic [RCW-1:0]    reveal_cols;
    logic [COORD_W:0]  dx, dy;
    logic              in_box, in_box_d, bit_on, gate;
    logic [CW-1:0]     col, col_d;
    logic [RW-1:0]     row;
    logic [MSG_W-1:0]  word, shifted;

    assign dx = {1'b0, DrawX} - (COORD_W + 1)'(X0);
    assign dy = {1'b0, DrawY} - (COORD_W + 1)'(Y0);

    // A latching pulse restarts the animation when the banner appears or its message/mode changes
    always_comb begin
        new_mode = decode_mode(mode);
        restart = (show && !show_q) || (msg_sel != active_msg) || (new_mode != active_mode);
    end

    // Frame-synchronous latching of requests and per-frame blink/reveal counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            show_q      <= 1'b0;
            active_msg  <= '0;
            active_mode <= STATIC;
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
            reveal_cols <= '0;
        end else if (frame_start) begin
            show_q      <= show;
            active_msg  <= msg_sel;
            active_mode <= new_mode;
            if (restart) begin
                blink_phase <= 1'b1;
                blink_cnt   <= '0;
                reveal_cols <= '0;
            end else if (show_q) begin
                blink_phase <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? ~blink_phase : blink_phase;
                blink_cnt   <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + BW'(1);
                reveal_cols <= (reveal_cols == RCW'(MSG_W)) ? reveal_cols : reveal_cols + RCW'(1);
            end
        end
    end

    // Two-stage pixel pipeline: box test and bitmap coordinates, then aligned with the ROM row
    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_box   <= 1'b0;
            col      <= '0;
            row      <= '0;
            in_box_d <= 1'b0;
            col_d    <= '0;
        end else begin
            in_box   <= !dx[COORD_W] && !dy[COORD_W] &&
                        dx < (COORD_W + 1)'(MSG_W << SCALE_LOG2) &&
                        dy < (COORD_W + 1)'(MSG_H << SCALE_LOG2);
            col      <= CW'(dx >> SCALE_LOG2);
            row      <= RW'(dy >> SCALE_LOG2);
            in_box_d <= in_box;
            col_d    <= col;
        end
    end

    banner_rom #(
        .MSG_W  (MSG_W),
        .MSG_H  (MSG_H),
        .NUM_MSG(NUM_MSG)
    ) u_rom (
        .Clk  (Clk),
        .Reset(Reset),
        .msg  (active_msg),
        .row  (row),
        .word (word)
    );

    // Final gating of the registered pipeline outputs by visibility and mode
    always_comb begin
        shifted     = word << col_d;
        bit_on      = shifted[MSG_W-1];
        gate        = (active_mode == BLINK) ? blink_phase :
                      (active_mode == REVEAL) ? (int'(col_d) < int'(reveal_cols)) : 1'b1;
        pixel_on    = in_box_d && bit_on && show_q && gate;
        reveal_done = (reveal_cols == RCW'(MSG_W)) && (active_mode == REVEAL);
    end
endmodule
